mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 86 ++++++++
 tb/tb_mem_access_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Single-port memory access sequencer: accepts one CPU request at a time and
// steps it through address setup, a timed rd/wr strobe, hold, and response.
module mem_access_ctrl #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [11:0] req_addr,
  input  logic [18:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [18:0] rsp_rdata,
  output logic [11:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [18:0] mem_wdata,
  input  logic [18:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    RESP   = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        we_q;
  logic [3:0]  cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = SETUP;
      SETUP:   state_nxt = STROBE;
      STROBE:  if (cnt == 4'd0) state_nxt = HOLD;
      HOLD:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are captured only on the accept edge; the counter is
  // loaded in SETUP so STROBE lasts exactly WAIT_CYCLES+1 cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_rdata <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            mem_addr  <= req_addr;
            mem_wdata <= req_wdata;
          end
        end
        SETUP: cnt <= 4'(WAIT_CYCLES);
        STROBE: begin
          if (cnt == 4'd0) rsp_rdata <= we_q ? '0 : mem_rdata;
          else             cnt <= cnt - 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign mem_rd    = (state == STROBE) && !we_q;
  assign mem_wr    = (state == STROBE) && we_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench: three instances (WAIT_CYCLES 1, 0, 15) against a
// word-addressed memory reference model, directed table plus random traffic.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_we    [3];
  logic [11:0] req_addr  [3];
  logic [18:0] req_wdata [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [18:0] rsp_rdata [3];
  logic [11:0] mem_addr  [3];
  logic        mem_rd    [3];
  logic        mem_wr    [3];
  logic [18:0] mem_wdata [3];
  logic [18:0] mem_rdata [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_access_ctrl #(.WAIT_CYCLES(g == 0 ? 1 : (g == 1 ? 0 : 15))) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_rdata (rsp_rdata[g]),
      .mem_addr  (mem_addr[g]),
      .mem_rd    (mem_rd[g]),
      .mem_wr    (mem_wr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g])
    );
  end

  // Physical memory seen by each DUT; initial contents are addr>>1.
  logic [18:0] phys [3][4096];
  bit filled = 1'b0;
  always @(posedge clk) begin
    if (!filled) begin
      for (int d = 0; d < 3; d++)
        for (int a = 0; a < 4096; a++) phys[d][a] <= 19'(a >> 1);
      filled <= 1'b1;
    end else begin
      for (int d = 0; d < 3; d++)
        if (mem_wr[d]) phys[d][mem_addr[d]] <= mem_wdata[d];
    end
  end

  always_comb begin
    for (int d = 0; d < 3; d++) mem_rdata[d] = phys[d][mem_addr[d]];
  end

  // Reference model of memory contents, updated from the bench's own intent.
  logic [18:0] ref_mem [3][4096];

  function automatic int wc(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 0 : 15);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Runs one transaction; caller is positioned at a negedge.
  task automatic txn(input int d, input logic we, input logic [11:0] a,
                     input logic [18:0] wd, input int hold, input bit keep_valid,
                     input logic [18:0] exp_rd);
    int  w;
    int  k;
    int  rd_cnt;
    int  wr_cnt;
    int  lat;
    bit  done;
    w = wc(d);
    k = 0;
    while (req_ready[d] !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("req_ready_idle", 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    @(posedge clk); #1;
    if (!keep_valid) req_valid[d] = 1'b0;
    req_we[d]    = 1'($urandom);
    req_addr[d]  = 12'($urandom);
    req_wdata[d] = 19'($urandom);
    rd_cnt = 0; wr_cnt = 0; lat = 0; done = 1'b0;
    for (int c = 0; c <= 40 && !done; c++) begin
      if (rsp_valid[d] === 1'b1) begin
        lat  = c;
        done = 1'b1;
      end else begin
        check("req_ready_busy", 32'(req_ready[d]), 32'd0);
        check("mem_addr_stable", 32'(mem_addr[d]), 32'(a));
        check("mem_wdata_stable", 32'(mem_wdata[d]), 32'(wd));
        check("rd_wr_exclusive", 32'(mem_rd[d] & mem_wr[d]), 32'd0);
        if (mem_rd[d] === 1'b1) rd_cnt++;
        if (mem_wr[d] === 1'b1) wr_cnt++;
        @(posedge clk); #1;
      end
    end
    check("latency", 32'(lat), 32'(3 + w));
    check("strobe_width", 32'(we ? wr_cnt : rd_cnt), 32'(w + 1));
    check("wrong_strobe", 32'(we ? rd_cnt : wr_cnt), 32'd0);
    check("rsp_rdata", 32'(rsp_rdata[d]), 32'(exp_rd));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("bp_rsp_valid", 32'(rsp_valid[d]), 32'd1);
      check("bp_rsp_rdata", 32'(rsp_rdata[d]), 32'(exp_rd));
      check("bp_req_ready", 32'(req_ready[d]), 32'd0);
    end
    @(negedge clk);
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    check("rsp_done", 32'(rsp_valid[d]), 32'd0);
    check("idle_ready", 32'(req_ready[d]), 32'd1);
    @(negedge clk);
    rsp_ready[d] = 1'b0;
  endtask

  typedef struct {
    int          d;
    logic        we;
    logic [11:0] addr;
    logic [18:0] wdata;
    int          hold;
    bit          keep;
    logic [18:0] exp;
  } vec_t;

  vec_t tbl [$];

  initial begin
    int          d;
    logic        we;
    logic [11:0] a;
    logic [18:0] wd;
    logic [18:0] ex;
    int          ones;

    tbl.push_back('{0, 1'b0, 12'h004, 19'h00000, 0, 1'b0, 19'h00002});
    tbl.push_back('{0, 1'b1, 12'h006, 19'h7FFFF, 0, 1'b0, 19'h00000});
    tbl.push_back('{0, 1'b0, 12'h006, 19'h00000, 0, 1'b0, 19'h7FFFF});
    tbl.push_back('{0, 1'b0, 12'h00A, 19'h00000, 3, 1'b1, 19'h00005});
    tbl.push_back('{0, 1'b0, 12'h008, 19'h00000, 0, 1'b0, 19'h00004});
    tbl.push_back('{1, 1'b0, 12'h004, 19'h00000, 0, 1'b0, 19'h00002});
    tbl.push_back('{1, 1'b1, 12'h010, 19'h12345, 1, 1'b0, 19'h00000});
    tbl.push_back('{1, 1'b0, 12'h010, 19'h00000, 0, 1'b0, 19'h12345});
    tbl.push_back('{2, 1'b0, 12'h004, 19'h00000, 0, 1'b0, 19'h00002});
    tbl.push_back('{2, 1'b1, 12'h011, 19'h00003, 2, 1'b0, 19'h00000});
    tbl.push_back('{2, 1'b0, 12'h011, 19'h00000, 0, 1'b0, 19'h00003});

    for (int i = 0; i < 3; i++) begin
      req_valid[i] = 1'b0;
      req_we[i]    = 1'b0;
      req_addr[i]  = '0;
      req_wdata[i] = '0;
      rsp_ready[i] = 1'b0;
      for (int j = 0; j < 4096; j++) ref_mem[i][j] = 19'(j >> 1);
    end

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_mem_rd", 32'(mem_rd[i]), 32'd0);
      check("rst_mem_wr", 32'(mem_wr[i]), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid[i]), 32'd0);
      check("rst_rsp_rdata", 32'(rsp_rdata[i]), 32'd0);
      check("rst_mem_addr", 32'(mem_addr[i]), 32'd0);
      check("rst_mem_wdata", 32'(mem_wdata[i]), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) check("post_rst_ready", 32'(req_ready[i]), 32'd1);
    @(negedge clk);

    // Abort a write mid-strobe with an asynchronous reset.
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = 12'h800;
    req_wdata[0] = 19'h01234;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_in_strobe", 32'(mem_wr[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_mem_wr", 32'(mem_wr[0]), 32'd0);
    check("abort_mem_addr", 32'(mem_addr[0]), 32'd0);
    check("abort_mem_wdata", 32'(mem_wdata[0]), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ones = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (rsp_valid[0] !== 1'b0) ones++;
    end
    check("abort_no_rsp", 32'(ones), 32'd0);
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].we) ref_mem[tbl[i].d][tbl[i].addr] = tbl[i].wdata;
      txn(tbl[i].d, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].hold, tbl[i].keep, tbl[i].exp);
    end

    for (int i = 0; i < 30; i++) begin
      d  = int'($urandom_range(0, 2));
      we = 1'($urandom);
      a  = 12'($urandom_range(0, 255));
      wd = 19'($urandom);
      if (we) begin
        ref_mem[d][a] = wd;
        ex = '0;
      end else begin
        ex = ref_mem[d][a];
      end
      txn(d, we, a, wd, int'($urandom_range(0, 3)), 1'b0, ex);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end

endmodule
